// File: rtl/ch_trigger_arbiter_if.sv
// Handshake bundle between the trigger arbiter and its environment:
// trigger levels and the done pulse in, the grant/status outputs out.
interface ch_trigger_arbiter_if #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
);
  logic [N_CH-1:0] i_req;
  logic            i_done;
  logic            o_start;
  logic [CH_W-1:0] o_ch_sel;
  logic            o_busy;
  logic [N_CH-1:0] o_pending;
  logic            o_timeout;

  modport master (
    output i_req,
    output i_done,
    input  o_start,
    input  o_ch_sel,
    input  o_busy,
    input  o_pending,
    input  o_timeout
  );

  modport slave (
    input  i_req,
    input  i_done,
    output o_start,
    output o_ch_sel,
    output o_busy,
    output o_pending,
    output o_timeout
  );
endinterface

// File: rtl/ch_trigger_arbiter.sv
// Round-robin arbiter sharing one channel datapath among N_CH edge-triggered
// requests; grants one channel at a time and waits for done or timeout.
module ch_trigger_arbiter #(
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  ch_trigger_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          state_q,   state_d;
  logic [N_CH-1:0] prev_q,    prev_d;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [CH_W-1:0] ptr_q,     ptr_d;
  logic [CH_W-1:0] ch_sel_q,  ch_sel_d;
  logic [TO_W-1:0] timer_q,   timer_d;
  logic            start_q,   start_d;
  logic            busy_q,    busy_d;
  logic            timeout_q, timeout_d;

  logic [N_CH-1:0] edge_s;
  logic [N_CH-1:0] clr_s;
  logic [CH_W-1:0] pick_s;

  // Rotate the request vector so the pointer sits at bit 0, take the lowest
  // set bit, then rotate the index back.
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                             input logic [CH_W-1:0] ptr);
    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic              found;
    int                idx;
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_CH-1:0];
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = i;
      end else begin
        found = found;
      end
    end
    idx = idx + int'(ptr);
    if (idx >= N_CH) begin
      idx = idx - N_CH;
    end else begin
      idx = idx;
    end
    return CH_W'(idx);
  endfunction

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    if (int'(ch) == N_CH - 1) begin
      return '0;
    end else begin
      return ch + CH_W'(1);
    end
  endfunction

  assign pick_s = rr_pick(pending_q, ptr_q);

  // Next-state, edge detection, pending bookkeeping and registered outputs.
  always_comb begin
    state_d   = state_q;
    prev_d    = bus.i_req;
    edge_s    = bus.i_req & ~prev_q;
    clr_s     = '0;
    ptr_d     = ptr_q;
    ch_sel_d  = ch_sel_q;
    timer_d   = timer_q;
    start_d   = 1'b0;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (pending_q != '0) begin
          ch_sel_d = pick_s;
          clr_s    = {{(N_CH-1){1'b0}}, 1'b1} << pick_s;
          state_d  = ST_START;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_START: begin
        start_d = 1'b1;
        busy_d  = 1'b1;
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busy_d = 1'b1;
        // A done arriving on the timeout cycle still counts as a clean finish.
        if (bus.i_done) begin
          ptr_d   = next_ch(ch_sel_q);
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
          ptr_d     = next_ch(ch_sel_q);
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // A fresh edge on the channel being granted re-queues it.
    pending_d = (pending_q & ~clr_s) | edge_s;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      ptr_q     <= '0;
      ch_sel_q  <= '0;
      timer_q   <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      ch_sel_q  <= ch_sel_d;
      timer_q   <= timer_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_start   = start_q;
  assign bus.o_ch_sel  = ch_sel_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_pending = pending_q;
  assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_ch_trigger_arbiter.sv
// Bench for ch_trigger_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a timestamp-based reference model.
module tb_ch_trigger_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   n_print;

  ch_trigger_arbiter_if #(.N_CH(N), .CH_W(2)) bus_if ();

  ch_trigger_arbiter #(.N_CH(N), .CH_W(2), .TIMEOUT(TO), .TO_W(4)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: a job is a (channel, selection time) pair.
  logic [N-1:0] m_prev;
  logic [N-1:0] m_pend;
  int           m_ptr;
  int           m_sel;
  bit           m_job;
  int           m_job_t;
  int           m_t;
  bit           m_start;
  bit           m_busy;
  bit           m_to;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [8:0] outs();
    return {bus_if.o_start, bus_if.o_busy, bus_if.o_timeout, bus_if.o_ch_sel, bus_if.o_pending};
  endfunction

  task automatic wait_start(input int limit, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < limit && !seen; n++) begin
      if (bus_if.o_start === 1'b1) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic give_done();
    bus_if.i_done = 1'b1;
    tick();
    bus_if.i_done = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs sampled at it.
  task automatic model_step(input logic [N-1:0] req, input bit done, input bit rst);
    logic [N-1:0] edges;
    logic [N-1:0] clr;
    int age;
    m_t++;
    if (!rst) begin
      m_prev = '0; m_pend = '0; m_ptr = 0; m_sel = 0; m_job = 1'b0;
      m_start = 1'b0; m_busy = 1'b0; m_to = 1'b0;
      return;
    end
    edges = req & ~m_prev;
    m_prev = req;
    clr = '0;
    m_start = 1'b0;
    m_to = 1'b0;
    if (!m_job) begin
      for (int o = 0; o < N && !m_job; o++) begin
        if (m_pend[(m_ptr + o) % N]) begin
          m_sel = (m_ptr + o) % N;
          clr[m_sel] = 1'b1;
          m_job = 1'b1;
          m_job_t = m_t;
        end
      end
    end else begin
      age = m_t - m_job_t;
      if (age == 1) begin
        m_start = 1'b1;
        m_busy = 1'b1;
      end else if (done) begin
        m_job = 1'b0; m_busy = 1'b0; m_ptr = (m_sel + 1) % N;
      end else if (age == TO + 1) begin
        m_job = 1'b0; m_busy = 1'b0; m_to = 1'b1; m_ptr = (m_sel + 1) % N;
      end
    end
    m_pend = (m_pend & ~clr) | edges;
  endtask

  task automatic test_reset();
    bit seen;
    int starts;
    rst_n = 1'b0;
    bus_if.i_req = 4'hF;
    bus_if.i_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (outs() !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_outs cyc%0d: got %b want %b", i, outs(), 9'd0);
      end
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus_if.o_pending !== 4'hF || bus_if.o_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_pend: got pend=%b start=%b want 1111 0", bus_if.o_pending, bus_if.o_start);
    end
    for (int c = 0; c < N; c++) begin
      wait_start(12, seen);
      n_tests++;
      if (!seen || bus_if.o_ch_sel !== 2'(c)) begin
        n_fail++;
        $display("FAIL reset_grant%0d: got start=%b ch_sel=%0d want start=1 ch_sel=%0d", c, seen, bus_if.o_ch_sel, c);
      end
      give_done();
    end
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.o_start === 1'b1) starts++;
      tick();
    end
    n_tests++;
    if (starts != 0) begin
      n_fail++;
      $display("FAIL reset_no_extra: got %0d starts want 0", starts);
    end
    bus_if.i_req = 4'h0;
    tick();
    tick();
  endtask

  task automatic test_single();
    bus_if.i_req = 4'b0100;
    tick();
    n_tests++;
    if (bus_if.o_pending !== 4'b0100 || bus_if.o_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pend: got pend=%b start=%b want 0100 0", bus_if.o_pending, bus_if.o_start);
    end
    tick();
    n_tests++;
    if (bus_if.o_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_start: got %b want 0", bus_if.o_start);
    end
    tick();
    n_tests++;
    if ({bus_if.o_start, bus_if.o_busy, bus_if.o_ch_sel, bus_if.o_pending} !== 8'b1_1_10_0000) begin
      n_fail++;
      $display("FAIL single_start: got %b want %b", {bus_if.o_start, bus_if.o_busy, bus_if.o_ch_sel, bus_if.o_pending}, 8'b11100000);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (bus_if.o_busy !== 1'b1 || bus_if.o_start !== 1'b0) begin
        n_fail++;
        $display("FAIL single_wait%0d: got busy=%b start=%b want 1 0", i, bus_if.o_busy, bus_if.o_start);
      end
    end
    give_done();
    n_tests++;
    if (bus_if.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_fall: got %b want 0", bus_if.o_busy);
    end
    bus_if.i_req = 4'h0;
    tick();
  endtask

  task automatic test_round_robin();
    bit seen;
    bus_if.i_req = 4'b0010;
    wait_start(12, seen);
    n_tests++;
    if (!seen || bus_if.o_ch_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL rr_first: got start=%b ch_sel=%0d want 1 1", seen, bus_if.o_ch_sel);
    end
    bus_if.i_req = 4'b1011;
    tick();
    n_tests++;
    if (bus_if.o_pending !== 4'b1001) begin
      n_fail++;
      $display("FAIL rr_pend: got %b want 1001", bus_if.o_pending);
    end
    give_done();
    wait_start(12, seen);
    n_tests++;
    if (!seen || bus_if.o_ch_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL rr_second: got start=%b ch_sel=%0d want 1 3", seen, bus_if.o_ch_sel);
    end
    give_done();
    wait_start(12, seen);
    n_tests++;
    if (!seen || bus_if.o_ch_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL rr_third: got start=%b ch_sel=%0d want 1 0", seen, bus_if.o_ch_sel);
    end
    give_done();
    bus_if.i_req = 4'h0;
    tick();
  endtask

  task automatic test_timeout();
    bit seen;
    bus_if.i_req = 4'b0100;
    wait_start(12, seen);
    n_tests++;
    if (!seen || bus_if.o_ch_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL to_start: got start=%b ch_sel=%0d want 1 2", seen, bus_if.o_ch_sel);
    end
    for (int n = 1; n <= TO; n++) begin
      tick();
      n_tests++;
      if (bus_if.o_timeout !== (n == TO) || bus_if.o_busy !== (n != TO)) begin
        n_fail++;
        $display("FAIL to_cyc%0d: got to=%b busy=%b want %b %b", n, bus_if.o_timeout, bus_if.o_busy, n == TO, n != TO);
      end
    end
    tick();
    n_tests++;
    if ({bus_if.o_timeout, bus_if.o_busy, bus_if.o_start} !== 3'b000) begin
      n_fail++;
      $display("FAIL to_pulse_end: got %b want 000", {bus_if.o_timeout, bus_if.o_busy, bus_if.o_start});
    end
    bus_if.i_req = 4'h0;
    tick();
    bus_if.i_req = 4'b0100;
    wait_start(12, seen);
    for (int n = 1; n < TO; n++) tick();
    give_done();
    n_tests++;
    if (bus_if.o_timeout !== 1'b0 || bus_if.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_done_wins: got to=%b busy=%b want 0 0", bus_if.o_timeout, bus_if.o_busy);
    end
    tick();
    n_tests++;
    if (bus_if.o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_done_late: got %b want 0", bus_if.o_timeout);
    end
    bus_if.i_req = 4'h0;
    tick();
  endtask

  task automatic test_retrigger();
    bit seen;
    int starts;
    bus_if.i_req = 4'b0010;
    wait_start(12, seen);
    bus_if.i_req = 4'b0011;
    tick();
    bus_if.i_req = 4'b0010;
    bus_if.i_done = 1'b1;
    tick();
    bus_if.i_done = 1'b0;
    bus_if.i_req = 4'b0011;
    tick();
    n_tests++;
    if (bus_if.o_pending !== 4'b0001 || bus_if.o_ch_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL retrig_keep: got pend=%b ch_sel=%0d want 0001 0", bus_if.o_pending, bus_if.o_ch_sel);
    end
    tick();
    n_tests++;
    if (bus_if.o_start !== 1'b1 || bus_if.o_pending !== 4'b0001) begin
      n_fail++;
      $display("FAIL retrig_start: got start=%b pend=%b want 1 0001", bus_if.o_start, bus_if.o_pending);
    end
    give_done();
    wait_start(12, seen);
    n_tests++;
    if (!seen || bus_if.o_ch_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL retrig_again: got start=%b ch_sel=%0d want 1 0", seen, bus_if.o_ch_sel);
    end
    give_done();
    bus_if.i_req = 4'h0;
    tick();
    bus_if.i_req = 4'b1000;
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus_if.o_start === 1'b1) begin
        starts++;
        bus_if.i_done = 1'b1;
      end else begin
        bus_if.i_done = 1'b0;
      end
      tick();
    end
    bus_if.i_done = 1'b0;
    n_tests++;
    if (starts != 1) begin
      n_fail++;
      $display("FAIL held_level: got %0d grants want 1", starts);
    end
    bus_if.i_req = 4'h0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    bus_if.i_req = 4'b0100;
    wait_start(12, seen);
    bus_if.i_req = 4'b0101;
    tick();
    n_tests++;
    if (bus_if.o_pending !== 4'b0001 || bus_if.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got pend=%b busy=%b want 0001 1", bus_if.o_pending, bus_if.o_busy);
    end
    rst_n = 1'b0;
    bus_if.i_req = 4'h0;
    tick();
    n_tests++;
    if (outs() !== 9'd0) begin
      n_fail++;
      $display("FAIL midrst_clear: got %b want %b", outs(), 9'd0);
    end
    rst_n = 1'b1;
    tick();
    give_done();
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (outs() !== 9'd0) begin
        n_fail++;
        $display("FAIL midrst_quiet%0d: got %b want %b", i, outs(), 9'd0);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] req_v;
    bit           done_v;
    bit           rst_v;
    logic [8:0]   exp_v;
    m_t = 0;
    req_v = '0;
    rst_n = 1'b0;
    bus_if.i_req = req_v;
    bus_if.i_done = 1'b0;
    tick();
    model_step(req_v, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 800; cyc++) begin
      req_v  = req_v ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      done_v = ($urandom_range(0, 5) == 0);
      rst_v  = ($urandom_range(0, 149) != 0);
      rst_n = rst_v;
      bus_if.i_req = req_v;
      bus_if.i_done = done_v;
      tick();
      model_step(req_v, done_v, rst_v);
      exp_v = {m_start, m_busy, m_to, 2'(m_sel), m_pend};
      n_tests++;
      if (outs() !== exp_v) begin
        n_fail++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL random cyc%0d: got %b want %b (start,busy,to,sel,pend)", cyc, outs(), exp_v);
        end
      end
    end
    rst_n = 1'b1;
    bus_if.i_done = 1'b0;
    bus_if.i_req = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    n_print = 0;
    rst_n = 1'b0;
    bus_if.i_req = '0;
    bus_if.i_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_retrigger();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
